// File: rtl/icache_pkg.sv
// Shared constants for the instruction cache: default widths and FSM state encoding.
package icache_pkg;

    localparam int unsigned AddressWidth = 32;
    localparam int unsigned IDWidth      = 32;

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StMiss = 1'b1;

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays of the direct-mapped icache: combinational read port, one write port,
// valid bits cleared by asynchronous reset or synchronous flush.
module icache_line_store
    import icache_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned TAG_BITS   = 24,
    parameter int unsigned DATA_BITS  = IDWidth
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  flush,
    input  logic [INDEX_BITS-1:0] rd_index,
    output logic                  rd_valid,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [DATA_BITS-1:0]  rd_data,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [DATA_BITS-1:0]  wr_data
);

    localparam int unsigned Lines = 2 ** INDEX_BITS;

    logic [Lines-1:0]     valid_q;
    logic [TAG_BITS-1:0]  tag_q  [Lines];
    logic [DATA_BITS-1:0] data_q [Lines];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (en) begin
            if (flush) begin
                valid_q <= '0;
            end else if (wr_en) begin
                valid_q[wr_index] <= 1'b1;
            end
        end
    end

    // Tag/data need no reset: they are only trusted behind a set valid bit.
    always_ff @(posedge clk) begin
        if (en && wr_en && !flush) begin
            tag_q[wr_index]  <= wr_tag;
            data_q[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/icache.sv
// Direct-mapped one-word-per-line instruction cache between fetch and the RAM controller's
// instruction port; handles miss fill, fetch cancellation and whole-cache flush.
module icache
    import icache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = AddressWidth,
    parameter int unsigned INST_WIDTH = IDWidth,
    parameter int unsigned INDEX_BITS = 6
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  if_en_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    input  logic                  cancel_i,
    input  logic                  flush_i,
    output logic                  if_rdy_o,
    output logic [INST_WIDTH-1:0] if_inst_o,
    output logic                  mem_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_rdy_i,
    input  logic [INST_WIDTH-1:0] mem_inst_i
);

    localparam int unsigned TagBits = ADDR_WIDTH - INDEX_BITS - 2;

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic                  cancelled_q, cancelled_d;
    logic                  drop_q, drop_d;
    logic                  if_rdy_q, if_rdy_d;
    logic [INST_WIDTH-1:0] if_inst_q, if_inst_d;

    logic                  rd_valid;
    logic [TagBits-1:0]    rd_tag;
    logic [INST_WIDTH-1:0] rd_data;
    logic                  wr_en;
    logic                  hit;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^if_addr_i[1:0];

    icache_line_store #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TagBits),
        .DATA_BITS  (INST_WIDTH)
    ) u_line_store (
        .clk      (clk_in),
        .rst_n    (rst_in),
        .en       (rdy_in),
        .flush    (flush_i),
        .rd_index (if_addr_i[INDEX_BITS+1:2]),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_index (req_addr_q[INDEX_BITS+1:2]),
        .wr_tag   (req_addr_q[ADDR_WIDTH-1:INDEX_BITS+2]),
        .wr_data  (mem_inst_i)
    );

    assign hit = rd_valid && (rd_tag == if_addr_i[ADDR_WIDTH-1:INDEX_BITS+2]);

    always_comb begin
        state_d     = state_q;
        req_addr_d  = req_addr_q;
        cancelled_d = cancelled_q;
        drop_d      = drop_q;
        if_rdy_d    = 1'b0;
        if_inst_d   = if_inst_q;
        wr_en       = 1'b0;
        case (state_q)
            StIdle: begin
                // The response cycle is skipped so fetch can present its next address.
                if (if_en_i && !if_rdy_q && !cancel_i && !flush_i) begin
                    if (hit) begin
                        if_rdy_d  = 1'b1;
                        if_inst_d = rd_data;
                    end else begin
                        req_addr_d  = {if_addr_i[ADDR_WIDTH-1:2], 2'b00};
                        cancelled_d = 1'b0;
                        drop_d      = 1'b0;
                        state_d     = StMiss;
                    end
                end
            end
            StMiss: begin
                if (cancel_i || flush_i) cancelled_d = 1'b1;
                if (flush_i) drop_d = 1'b1;
                if (mem_rdy_i) begin
                    wr_en = !drop_q && !flush_i;
                    if (!cancelled_q && !cancel_i && !flush_i) begin
                        if_rdy_d  = 1'b1;
                        if_inst_d = mem_inst_i;
                    end
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= StIdle;
            req_addr_q  <= '0;
            cancelled_q <= 1'b0;
            drop_q      <= 1'b0;
            if_rdy_q    <= 1'b0;
            if_inst_q   <= '0;
        end else if (rdy_in) begin
            state_q     <= state_d;
            req_addr_q  <= req_addr_d;
            cancelled_q <= cancelled_d;
            drop_q      <= drop_d;
            if_rdy_q    <= if_rdy_d;
            if_inst_q   <= if_inst_d;
        end
    end

    // Dropping the request while rdy is high keeps the controller from starting a second read.
    assign mem_en_o   = (state_q == StMiss) && !mem_rdy_i;
    assign mem_addr_o = req_addr_q;
    assign if_rdy_o   = if_rdy_q;
    assign if_inst_o  = if_inst_q;

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: RAM responder model plus a response scoreboard.
module tb_icache;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        if_en_i;
    logic [31:0] if_addr_i;
    logic        cancel_i;
    logic        flush_i;
    logic        if_rdy_o;
    logic [31:0] if_inst_o;
    logic        mem_en_o;
    logic [31:0] mem_addr_o;
    logic        mem_rdy_i;
    logic [31:0] mem_inst_i;

    int          n_checks  = 0;
    int          n_fail    = 0;
    int          rsp_count = 0;
    int          mem_cnt   = 0;
    int          mem_lat   = 4;
    logic [31:0] exp_q[$];

    icache dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .if_en_i    (if_en_i),
        .if_addr_i  (if_addr_i),
        .cancel_i   (cancel_i),
        .flush_i    (flush_i),
        .if_rdy_o   (if_rdy_o),
        .if_inst_o  (if_inst_o),
        .mem_en_o   (mem_en_o),
        .mem_addr_o (mem_addr_o),
        .mem_rdy_i  (mem_rdy_i),
        .mem_inst_i (mem_inst_i)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        if (a == 32'h100) return 32'h0000_0013;
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    // RAM controller stand-in: answers mem_lat enabled cycles after a request appears.
    initial begin
        mem_rdy_i  = 1'b0;
        mem_inst_i = '0;
        forever begin
            @(posedge clk_in);
            #2;
            mem_rdy_i = 1'b0;
            if (!rst_in) begin
                mem_cnt = 0;
            end else if (mem_en_o && rdy_in) begin
                if (mem_cnt == mem_lat) begin
                    mem_rdy_i  = 1'b1;
                    mem_inst_i = ram_word(mem_addr_o);
                    mem_cnt    = 0;
                end else begin
                    mem_cnt++;
                end
            end else if (!mem_en_o) begin
                mem_cnt = 0;
            end
        end
    end

    // Scoreboard: every consumed response pops one expectation.
    always @(negedge clk_in) begin
        if (rst_in && rdy_in && if_rdy_o) begin
            rsp_count++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_rsp: got if_inst_o=%h, required no response", if_inst_o);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (if_inst_o !== e) begin
                    n_fail++;
                    $display("FAIL rsp_data: got if_inst_o=%h, required %h", if_inst_o, e);
                end
            end
        end
    end

    task automatic wait_rsp(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk_in); #1;
            n++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: %0d responses outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        @(posedge clk_in); #1;
    endtask

    task automatic fetch(input logic [31:0] addr, input bit hit, input string name);
        logic [31:0] wa;
        wa = {addr[31:2], 2'b00};
        exp_q.push_back(ram_word(wa));
        if_en_i = 1'b1;
        if_addr_i = addr;
        @(posedge clk_in); #1;
        if_en_i = 1'b0;
        n_checks++;
        if (hit) begin
            if (if_rdy_o !== 1'b1 || mem_en_o !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_hit: if_rdy_o=%b mem_en_o=%b, required 1/0", name, if_rdy_o,
                         mem_en_o);
            end
        end else begin
            if (mem_en_o !== 1'b1 || mem_addr_o !== wa) begin
                n_fail++;
                $display("FAIL %s_miss: mem_en_o=%b mem_addr_o=%h, required 1/%h", name, mem_en_o,
                         mem_addr_o, wa);
            end
        end
        wait_rsp(name);
    endtask

    task automatic req_only(input logic [31:0] addr);
        if_en_i = 1'b1;
        if_addr_i = addr;
        @(posedge clk_in); #1;
        if_en_i = 1'b0;
    endtask

    task automatic pulse_flush();
        flush_i = 1'b1;
        @(posedge clk_in); #1;
        flush_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b0; rdy_in = 1'b1; if_en_i = 1'b0; if_addr_i = '0;
        cancel_i = 1'b0; flush_i = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        n_checks++;
        if (if_rdy_o !== 1'b0 || if_inst_o !== 32'h0 || mem_en_o !== 1'b0
            || mem_addr_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_vals: rdy=%b inst=%h mem_en=%b mem_addr=%h, required all 0",
                     if_rdy_o, if_inst_o, mem_en_o, mem_addr_o);
        end
        rst_in = 1'b1;
        @(posedge clk_in); #1;
    endtask

    task automatic test_cold_miss_hit();
        fetch(32'h100, 1'b0, "cold_miss");
        fetch(32'h100, 1'b1, "refetch_hit");
    endtask

    task automatic test_back_to_back();
        int rc = rsp_count;
        exp_q.push_back(32'h13);
        exp_q.push_back(32'h13);
        if_en_i = 1'b1;
        if_addr_i = 32'h100;
        repeat (4) begin
            @(posedge clk_in); #1;
        end
        if_en_i = 1'b0;
        wait_rsp("b2b");
        n_checks++;
        if (rsp_count - rc != 2) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d responses, required 2", rsp_count - rc);
        end
    endtask

    task automatic test_conflict();
        fetch(32'h200, 1'b0, "evict_200");
        fetch(32'h100, 1'b0, "evict_100");
        fetch(32'h200, 1'b0, "evict_200b");
    endtask

    task automatic test_cancel();
        int rc = rsp_count;
        int n = 0;
        req_only(32'h104);
        @(posedge clk_in); #1;
        cancel_i = 1'b1;
        @(posedge clk_in); #1;
        cancel_i = 1'b0;
        while (mem_en_o && n < 50) begin
            @(posedge clk_in); #1;
            n++;
        end
        repeat (3) @(posedge clk_in);
        #1;
        n_checks++;
        if (rsp_count != rc) begin
            n_fail++;
            $display("FAIL cancel_rsp: got %0d responses, required 0", rsp_count - rc);
        end
        fetch(32'h104, 1'b1, "cancel_then_hit");
    endtask

    task automatic test_flush();
        fetch(32'h100, 1'b0, "flush_fill");
        pulse_flush();
        fetch(32'h100, 1'b0, "flush_refetch");
    endtask

    task automatic test_flush_fill_race();
        int rc = rsp_count;
        int n = 0;
        req_only(32'h200);
        while (!mem_rdy_i && n < 50) begin
            @(posedge clk_in); #3;
            n++;
        end
        n_checks++;
        if (mem_rdy_i !== 1'b1) begin
            n_fail++;
            $display("FAIL race_mem_rdy: mem_rdy_i=%b, required 1", mem_rdy_i);
        end
        flush_i = 1'b1;
        @(posedge clk_in); #1;
        flush_i = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        n_checks++;
        if (rsp_count != rc) begin
            n_fail++;
            $display("FAIL race_rsp: got %0d responses, required 0", rsp_count - rc);
        end
        fetch(32'h200, 1'b0, "race_line_invalid");
    endtask

    task automatic test_stall();
        int rc = rsp_count;
        exp_q.push_back(ram_word(32'h304));
        req_only(32'h304);
        @(posedge clk_in); #1;
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_in); #1;
            n_checks++;
            if (mem_en_o !== 1'b1 || mem_addr_o !== 32'h304 || if_rdy_o !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold: mem_en_o=%b mem_addr_o=%h if_rdy_o=%b, required 1/304/0",
                         mem_en_o, mem_addr_o, if_rdy_o);
            end
        end
        rdy_in = 1'b1;
        wait_rsp("stall");
        repeat (3) @(posedge clk_in);
        #1;
        n_checks++;
        if (rsp_count - rc != 1) begin
            n_fail++;
            $display("FAIL stall_count: got %0d responses, required 1", rsp_count - rc);
        end
    endtask

    task automatic test_unaligned();
        pulse_flush();
        fetch(32'h103, 1'b0, "unaligned");
    endtask

    task automatic test_async_reset();
        req_only(32'h400);
        @(posedge clk_in); #1;
        n_checks++;
        if (mem_en_o !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_pre: mem_en_o=%b, required 1", mem_en_o);
        end
        #3;
        rst_in = 1'b0;
        #1;
        n_checks++;
        if (mem_en_o !== 1'b0 || if_rdy_o !== 1'b0 || mem_addr_o !== 32'h0) begin
            n_fail++;
            $display("FAIL areset_now: mem_en_o=%b if_rdy_o=%b mem_addr_o=%h, required 0/0/0",
                     mem_en_o, if_rdy_o, mem_addr_o);
        end
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        fetch(32'h100, 1'b0, "areset_inval_100");
        fetch(32'h304, 1'b0, "areset_inval_304");
    endtask

    initial begin
        test_reset();
        test_cold_miss_hit();
        test_back_to_back();
        test_conflict();
        test_cancel();
        test_flush();
        test_flush_fill_race();
        test_stall();
        test_unaligned();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
